binary_to_bcd_seq: RTL
======================

// Module: binary_to_bcd_seq
// PURPOSE
//  Sequential, parametrised double-dabble converter: one input bit per clock, start/done handshake.
//  Produces BCD digits, a leading-zero blanking mask, and a saturating overflow flag.
//  Sits between arithmetic/counter logic and the 7-segment display driver on the Nexys A7.
//  Replaces the combinational 27-bit/8-digit converter where timing or area matters.
// PARAMETERS
//  BIN_WIDTH  27  width of binary input; conversion takes BIN_WIDTH shift cycles (>=1)
//  DIGITS     8   number of BCD output digits; result range 0 .. 10^DIGITS-1 (>=1)
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  reset        in   1            synchronous, active-high reset
//  start        in   1            request conversion; accepted only when ready=1
//  bin_in       in   BIN_WIDTH    binary value; sampled only on the accepting edge
//  ready        out  1            1 when a start will be accepted (state IDLE or DONE)
//  busy         out  1            1 while state SHIFT
//  done         out  1            one-cycle pulse: bcd_out/digit_valid/overflow updated
//  bcd_out      out  4*DIGITS     result; digit k in [4k+3:4k], digit 0 = units
//  digit_valid  out  DIGITS       blanking mask: bit k=1 if digit k or any higher digit nonzero; bit0 always 1
//  overflow     out  1            1 if last input >= 10^DIGITS
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, shift count=0, scratch=0; ready=1, busy=0, done=0,
//    bcd_out=0, digit_valid={DIGITS{1'b0}} with bit0=1, overflow=0. Overrides every other input.
//  - States: IDLE, SHIFT, DONE. ready = (state!=SHIFT); busy = (state==SHIFT); done = (state==DONE).
//  - IDLE/DONE + start=1 at edge E0: latch bin_in into shift reg, clear BCD scratch and sticky ovf,
//    load count=BIN_WIDTH, go to SHIFT. DONE + start=0: go to IDLE. IDLE + start=0: stay.
//  - SHIFT, each edge: (1) every scratch digit >=5 gets +3 (4-bit, all digits in parallel);
//    (2) sticky ovf |= scratch MSB after step 1 (bit lost on shift => value >= 10^DIGITS);
//    (3) {scratch, shreg} shift left 1, input MSB first; (4) count-1.
//    On the edge where count goes 1->0: register outputs, go to DONE.
//  - Output register on completion: overflow=sticky ovf; bcd_out = overflow ? all 4'h9 : scratch;
//    digit_valid computed from the value written to bcd_out (all ones on overflow).
//  - Latency: start sampled at E0, shifts at E1..E_BIN_WIDTH, done=1 for the cycle after E_BIN_WIDTH.
//    Back-to-back: start during the done cycle is accepted; throughput one result per BIN_WIDTH+1 clocks.
//  - start while busy is ignored (no queueing); bin_in changes while busy have no effect.
//  - bcd_out/digit_valid/overflow hold the last result until the next done; never glitch mid-conversion.
//  - Reset mid-SHIFT aborts: no done pulse, outputs return to reset values.
//  - Count register width $clog2(BIN_WIDTH+1); no combinational path from start/bin_in to any output.
// TESTING
//  1. Reset, start with bin_in=0 -> done exactly 27 cycles after accept edge; bcd_out=32'h00000000,
//     digit_valid=8'h01, overflow=0.
//  2. bin_in=99_999_999 -> bcd_out=32'h99999999, digit_valid=8'hFF, overflow=0;
//     bin_in=100_000_000 -> overflow=1, bcd_out=32'h99999999; bin_in=2^27-1 -> overflow=1.
//  3. bin_in=12345, then start pulsed with bin_in=777 at SHIFT cycle 5 -> single done,
//     bcd_out=32'h00012345, digit_valid=8'h1F; second start ignored, ready=0 throughout SHIFT.
//  4. Start during done cycle with bin_in=40 -> second done 28 cycles after first; bcd_out=32'h00000040,
//     digit_valid=8'h03; done is exactly one cycle wide both times.
//  5. Reset asserted at SHIFT cycle 10 -> no done, all outputs at reset values next cycle, ready=1;
//     new start afterwards converts correctly (bin_in=500 -> 32'h00000500).
//  6. BIN_WIDTH=8, DIGITS=3: 255 -> 12'h255, done 8 cycles after accept, mask 3'b111;
//     BIN_WIDTH=8, DIGITS=2: 255 -> overflow=1, 8'h99; 99 -> 8'h99, overflow=0.
//  Bench checks every result against a behavioural model over a random sweep (>=10k values) per config.

Source files
------------

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/done handshake, leading-zero mask and saturating overflow.
module binary_to_bcd_seq #(
  parameter int unsigned BIN_WIDTH = 27,
  parameter int unsigned DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIN_WIDTH-1:0] r_shreg;
  logic [BCD_W-1:0]     r_scratch;
  logic                 r_ovf;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_scratch_next;
  logic [BCD_W-1:0]     w_final;
  logic                 w_ovf_next;
  logic [DIGITS-1:0]    w_mask;
  logic                 w_seen;
  logic                 w_last;

  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // A set MSB after adjustment would be shifted out: value no longer fits.
  assign w_ovf_next     = r_ovf | w_adj[BCD_W-1];
  assign w_scratch_next = {w_adj[BCD_W-2:0], r_shreg[BIN_WIDTH-1]};
  assign w_final        = w_ovf_next ? {DIGITS{4'h9}} : w_scratch_next;
  assign w_last         = (r_cnt == CNT_W'(1));

  always_comb begin
    w_mask = '0;
    w_seen = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      w_seen    = w_seen | (w_final[4*k +: 4] != 4'h0);
      w_mask[k] = w_seen;
    end
    w_mask[0] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_scratch   <= '0;
      r_ovf       <= 1'b0;
      bcd_out     <= '0;
      digit_valid <= DIGITS'(1);
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_shreg   <= bin_in;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CNT_W'(BIN_WIDTH);
          end
        end
        StShift: begin
          r_scratch <= w_scratch_next;
          r_shreg   <= r_shreg << 1;
          r_ovf     <= w_ovf_next;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (w_last) begin
            bcd_out     <= w_final;
            digit_valid <= w_mask;
            overflow    <= w_ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state != StShift);
  assign busy  = (r_state == StShift);
  assign done  = (r_state == StDone);

endmodule
